// File: rtl/pll_clken_mgr_if.sv
// Bus bundle for pll_clken_mgr: lock input, divisor programming, reset release and clock-enable outputs.
interface pll_clken_mgr_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = 8
);
  logic                      pll_lock;
  logic [NUM_CH*DIV_W-1:0]   div_sel;
  logic                      div_load;
  logic                      sys_reset;
  logic                      lock_ok;
  logic                      lock_lost;
  logic [NUM_CH-1:0]         clk_en;
  logic [NUM_CH-1:0]         clk_en_p;
  logic                      div_busy;

  modport master (
    output pll_lock, div_sel, div_load,
    input  sys_reset, lock_ok, lock_lost, clk_en, clk_en_p, div_busy
  );

  modport slave (
    input  pll_lock, div_sel, div_load,
    output sys_reset, lock_ok, lock_lost, clk_en, clk_en_p, div_busy
  );
endinterface

// File: rtl/pll_clken_mgr.sv
// PLL lock qualifier, system reset sequencer and NUM_CH programmable clock-enable dividers.
// Optional macro PLL_CLKEN_SYNC_LOAD_EN: div_load applies to all channels next cycle and realigns them.
module pll_clken_mgr #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DIV_INIT  = 2,
  parameter int unsigned LOCK_FILT = 16,
  parameter int unsigned RST_HOLD  = 8
) (
  input  logic            clk,
  input  logic            reset,
  pll_clken_mgr_if.slave  bus
);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("pll_clken_mgr: NUM_CH must be 1..8");
  end
  if (LOCK_FILT < 1 || RST_HOLD < 1) begin : g_bad_timing
    $error("pll_clken_mgr: LOCK_FILT and RST_HOLD must be >= 1");
  end

  localparam int unsigned CNT_MAX = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    HOLD,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_lost_q, lock_lost_d;
  logic               run;
  logic [NUM_CH-1:0]  pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      WAIT_LOCK: begin
        if (bus.pll_lock) begin
          state_d = FILTER;
          cnt_d   = '0;
        end
      end
      FILTER: begin
        if (!bus.pll_lock) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CNT_W'(LOCK_FILT - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!bus.pll_lock) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!bus.pll_lock) begin
          state_d     = WAIT_LOCK;
          lock_lost_d = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign run           = (state_q == RUN);
  assign bus.sys_reset = !run;
  assign bus.lock_ok   = (state_q == HOLD) || run;
  assign bus.lock_lost = lock_lost_q;
  assign bus.div_busy  = |pend;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_ch_q;
    logic [DIV_W-1:0] n_eff;
    logic [DIV_W-1:0] sel;
    logic             wrap;

    assign sel   = bus.div_sel[i*DIV_W +: DIV_W];
    assign n_eff = (div_q == '0) ? DIV_W'(1) : div_q;
    assign wrap  = (cnt_ch_q == n_eff - DIV_W'(1));

`ifdef PLL_CLKEN_SYNC_LOAD_EN
    // Every channel restarts at 0 on a load, keeping all channels phase-aligned.
    always_ff @(posedge clk) begin
      if (reset) begin
        div_q    <= DIV_W'(DIV_INIT);
        cnt_ch_q <= '0;
      end else if (bus.div_load) begin
        div_q    <= sel;
        cnt_ch_q <= '0;
      end else begin
        cnt_ch_q <= (run && !wrap) ? cnt_ch_q + DIV_W'(1) : '0;
      end
    end

    assign pend[i] = 1'b0;
`else
    logic [DIV_W-1:0] shadow_q;
    logic             pend_q;

    // In RUN the new divisor only lands on a wrap, so a running period is never cut short;
    // a load on the wrap cycle itself bypasses the shadow.
    always_ff @(posedge clk) begin
      if (reset) begin
        div_q    <= DIV_W'(DIV_INIT);
        shadow_q <= '0;
        pend_q   <= 1'b0;
        cnt_ch_q <= '0;
      end else begin
        cnt_ch_q <= (run && !wrap) ? cnt_ch_q + DIV_W'(1) : '0;
        if (run) begin
          if (wrap && bus.div_load) begin
            div_q  <= sel;
            pend_q <= 1'b0;
          end else if (wrap && pend_q) begin
            div_q  <= shadow_q;
            pend_q <= 1'b0;
          end else if (bus.div_load) begin
            shadow_q <= sel;
            pend_q   <= 1'b1;
          end
        end else begin
          if (pend_q) begin
            div_q <= shadow_q;
          end
          pend_q <= bus.div_load;
          if (bus.div_load) begin
            shadow_q <= sel;
          end
        end
      end
    end

    assign pend[i] = pend_q;
`endif

    assign bus.clk_en[i]   = run && (cnt_ch_q == '0);
    assign bus.clk_en_p[i] = run && (cnt_ch_q == (n_eff >> 1));
  end

endmodule
